// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving a 10-bit Montgomery multiplier (MMM).
// Build option MODEXP_SKIP_LZ_EN: skip the squarings above the most significant set exponent bit.
//
//   state | meaning
//   IDLE  | waiting for start_i, operands forced to zero
//   PRE_M | msg * R^2 -> xbar (message into Montgomery domain)
//   PRE_A | 1 * R^2   -> abar (accumulator = R mod n)
//   SQ    | abar * abar -> abar for exponent bit idx
//   MUL   | abar * xbar -> abar when exponent bit idx is set
//   POST  | abar * 1 -> abar (back to the plain domain)
//   DONE  | completion pulse, publish result
module modexp_sequencer #(
    parameter int WIDTH    = 10,
    parameter int EXP_BITS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [WIDTH-1:0]    msg_i,
    input  logic [EXP_BITS-1:0] exp_i,
    input  logic [WIDTH-1:0]    r2_i,
    input  logic                mmm_done_i,
    input  logic [WIDTH-1:0]    mmm_result_i,
    output logic [WIDTH-1:0]    op_x_o,
    output logic [WIDTH-1:0]    op_y_o,
    output logic                mmm_start_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [WIDTH-1:0]    result_o
);
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_M, S_PRE_A, S_SQ, S_MUL, S_POST, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    abar_q, abar_d;
    logic [WIDTH-1:0]    xbar_q, xbar_d;
    logic [EXP_BITS-1:0] e_q, e_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                issued_q, issued_d;
    logic [WIDTH-1:0]    result_q, result_d;

    logic [1:0] sel_x, sel_y;
    logic       issue, step, lz_skip;

    function automatic logic [WIDTH-1:0] sel_mux(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (sel)
            SEL_A:   sel_mux = a;
            SEL_B:   sel_mux = b;
            SEL_ONE: sel_mux = WIDTH'(1);
            default: sel_mux = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            abar_q   <= '0;
            xbar_q   <= '0;
            e_q      <= '0;
            idx_q    <= '0;
            issued_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            abar_q   <= abar_d;
            xbar_q   <= xbar_d;
            e_q      <= e_d;
            idx_q    <= idx_d;
            issued_q <= issued_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        abar_d   = abar_q;
        xbar_d   = xbar_q;
        e_d      = e_q;
        idx_d    = idx_q;
        issued_d = issued_q;
        result_d = result_q;
        sel_x    = SEL_ZERO;
        sel_y    = SEL_ZERO;
        issue    = 1'b0;
        step     = 1'b0;
        lz_skip  = 1'b0;
`ifdef MODEXP_SKIP_LZ_EN
        // Squaring R in the Montgomery domain yields R, so leading-zero squarings are no-ops.
        lz_skip  = ((e_q >> idx_q) == '0);
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    e_d     = exp_i;
                    xbar_d  = r2_i;
                    abar_d  = r2_i;
                    idx_d   = IDX_TOP;
                    state_d = S_PRE_M;
                end
            end
            S_PRE_M: begin
                sel_x = SEL_B;
                sel_y = SEL_B;
                issue = 1'b1;
                if (mmm_done_i) begin
                    xbar_d  = mmm_result_i;
                    state_d = S_PRE_A;
                end
            end
            S_PRE_A: begin
                sel_x = SEL_ONE;
                sel_y = SEL_A;
                issue = 1'b1;
                if (mmm_done_i) begin
                    abar_d  = mmm_result_i;
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                sel_x = SEL_A;
                sel_y = SEL_A;
                if (lz_skip) begin
                    step = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (mmm_done_i) begin
                        abar_d = mmm_result_i;
                        if (e_q[idx_q]) state_d = S_MUL;
                        else            step    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                sel_x = SEL_A;
                sel_y = SEL_B;
                issue = 1'b1;
                if (mmm_done_i) begin
                    abar_d = mmm_result_i;
                    step   = 1'b1;
                end
            end
            S_POST: begin
                sel_x = SEL_A;
                sel_y = SEL_ONE;
                issue = 1'b1;
                if (mmm_done_i) begin
                    abar_d  = mmm_result_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = abar_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (step) begin
            if (idx_q == '0) begin
                state_d = S_POST;
            end else begin
                idx_d   = idx_q - 1'b1;
                state_d = S_SQ;
            end
        end

        // A done in the start cycle itself is accepted (zero-latency multiplier).
        if (issue) issued_d = !mmm_done_i;
    end

    assign op_x_o      = sel_mux(sel_x, abar_q, msg_i);
    assign op_y_o      = sel_mux(sel_y, abar_q, xbar_q);
    assign mmm_start_o = issue && !issued_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: behavioural MMM (n = 713, R = 1024) plus an expected operand-pair queue.
module tb_modexp_sequencer;
    localparam int N_MOD = 713;
    localparam int R2    = 466;
`ifdef MODEXP_SKIP_LZ_EN
    localparam int ST_E5 = 8;
    localparam int ST_E0 = 3;
`else
    localparam int ST_E5 = 15;
    localparam int ST_E0 = 13;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [9:0] msg_i = '0;
    logic [9:0] exp_i = '0;
    logic [9:0] r2_i = 10'(R2);
    logic       mmm_done_i = 1'b0;
    logic [9:0] mmm_result_i = '0;
    logic [9:0] op_x_o, op_y_o, result_o;
    logic       mmm_start_o, busy_o, done_o;

    modexp_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .msg_i(msg_i), .exp_i(exp_i),
        .r2_i(r2_i), .mmm_done_i(mmm_done_i), .mmm_result_i(mmm_result_i),
        .op_x_o(op_x_o), .op_y_o(op_y_o), .mmm_start_o(mmm_start_o),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          rinv = 0;
    int          lat_cfg = 3;
    int          starts_seen = 0;
    int          done_cnt = 0;
    int          exp_result = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int mont(input int a, input int b);
        longint p;
        p = (longint'(a) * longint'(b)) % N_MOD;
        p = (p * longint'(rinv)) % N_MOD;
        return int'(p);
    endfunction

    function automatic int plain_pow(input int m, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * m) % N_MOD;
        return r;
    endfunction

    task automatic push_op(input int a, input int b, inout int n);
        exp_q.push_back({10'(a), 10'(b)});
        n++;
    endtask

    // Expected multiplier operand sequence for one exponentiation.
    task automatic build_model(input int m, input int e, output int res, output int n);
        int mbar, a;
        bit skip;
        n = 0;
        exp_q.delete();
        push_op(m, R2, n); mbar = mont(m, R2);
        push_op(1, R2, n); a = mont(1, R2);
        for (int i = 9; i >= 0; i--) begin
            skip = 1'b0;
`ifdef MODEXP_SKIP_LZ_EN
            skip = ((e >> i) == 0);
`endif
            if (!skip) begin push_op(a, a, n); a = mont(a, a); end
            if (((e >> i) & 1) != 0) begin push_op(a, mbar, n); a = mont(a, mbar); end
        end
        push_op(a, 1, n); a = mont(a, 1);
        res = a;
    endtask

    // Behavioural MMM with configurable latency.
    int mmm_cnt = 0;
    bit mmm_pend = 1'b0;
    int mmm_pres = 0;
    always @(negedge clk) begin
        mmm_done_i = 1'b0;
        if (mmm_pend) begin
            mmm_cnt--;
            if (mmm_cnt == 0) begin
                mmm_done_i   = 1'b1;
                mmm_result_i = 10'(mmm_pres);
                mmm_pend     = 1'b0;
            end
        end
        if (rst_n && mmm_start_o) begin
            mmm_pres = mont(int'(op_x_o), int'(op_y_o));
            if (lat_cfg == 0) begin
                mmm_done_i   = 1'b1;
                mmm_result_i = 10'(mmm_pres);
            end else begin
                mmm_pend = 1'b1;
                mmm_cnt  = lat_cfg;
            end
        end
    end

    // Compare process: operand pairs at every start, hold until done, idle zeros, result after done.
    logic [19:0] held = '0;
    int          hold_left = 0;
    bit          res_chk = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_left = 0;
            res_chk   = 1'b0;
        end else begin
            if (res_chk) begin
                check("result_after_done", result_o, exp_result);
                res_chk = 1'b0;
            end
            if (!busy_o) begin
                check("idle_operands", {op_x_o, op_y_o}, 0);
                check("idle_start", mmm_start_o, 0);
            end
            if (hold_left > 0) begin
                check("operand_hold", {op_x_o, op_y_o}, held);
                hold_left--;
            end
            if (mmm_start_o) begin
                if (exp_q.size() == 0) check("unexpected_start", 1, 0);
                else check("operand_pair", {op_x_o, op_y_o}, exp_q.pop_front());
                starts_seen++;
                held      = {op_x_o, op_y_o};
                hold_left = lat_cfg;
            end
            if (done_o) begin
                done_cnt++;
                res_chk = 1'b1;
            end
        end
    end

    task automatic run(input int m, input int e, input int lat, input bit extra,
                       input int lit_res, input int lit_starts);
        int  mres, mstarts;
        bit  seen;
        build_model(m, e, mres, mstarts);
        check("model_vs_plain_pow", mres, plain_pow(m, e));
        if (lit_res >= 0) check("model_literal_result", mres, lit_res);
        check("model_start_count", mstarts, lit_starts);
        exp_result  = mres;
        lat_cfg     = lat;
        starts_seen = 0;
        done_cnt    = 0;
        msg_i       = 10'(m);
        exp_i       = 10'(e);
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_accept", busy_o, 1);
        seen = 1'b0;
        for (int b = 0; b < 3000 && !seen; b++) begin
            if (extra && b == 8) begin start_i = 1'b1; exp_i = 10'd1023; end
            else start_i = 1'b0;
            @(posedge clk); #1;
            if (done_o) seen = 1'b1;
        end
        start_i = 1'b0;
        exp_i   = 10'(e);
        check("done_seen_in_budget", seen, 1);
        @(posedge clk); #1;
        check("result_o", result_o, mres);
        check("busy_cleared", busy_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("start_count", starts_seen, lit_starts);
        check("done_pulse_count", done_cnt, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int dummy_res, dummy_n;
        for (int k = 1; k < N_MOD; k++) if ((1024 * k) % N_MOD == 1) rinv = k;
        check("mont_pin_r2", mont(1, R2), 1024 % N_MOD);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_result", result_o, 0);
        check("reset_ops", {op_x_o, op_y_o, mmm_start_o}, 0);

        run(2, 5, 3, 1'b0, 32, ST_E5);
        run(100, 0, 3, 1'b0, 1, ST_E0);
        run(2, 5, 3, 1'b1, 32, ST_E5);

        // Abort during the first issued squaring.
        lat_cfg = 3;
        build_model(2, 5, dummy_res, dummy_n);
        starts_seen = 0;
        msg_i = 10'd2; exp_i = 10'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int b = 0; b < 200 && starts_seen < 3; b++) begin
            @(posedge clk); #1;
        end
        check("reached_first_square", starts_seen, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_result", result_o, 0);
        check("abort_ops", {op_x_o, op_y_o, mmm_start_o}, 0);
        repeat (8) @(posedge clk);
        #1;
        check("late_done_ignored_starts", starts_seen, 3);
        check("late_done_ignored_busy", busy_o, 0);

        run(2, 5, 3, 1'b0, 32, ST_E5);
        run(5, 512, 1, 1'b0, -1, 14);
        run(3, 1023, 0, 1'b0, -1, 23);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
